// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame width,
// parity-mode constants and the receive status strobe bundle.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_e;

  localparam int DEFAULT_DATA_BITS = 8;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  // At most one field is set in any cycle.
  typedef struct packed {
    logic frame_err;
    logic parity_err;
    logic valid;
  } rx_status_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a history flop that
// yields a one-cycle falling-edge pulse. All flops reset to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);

  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= 3'b111;
    else       sr <= {sr[1:0], rx};
  end

  assign rx_s      = sr[1];
  assign fall_edge = sr[2] & ~sr[1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framing FSM: start/data/parity/stop sequencing on the
// mid-bit baud tick, with registered one-cycle result strobes.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 clk_baud,
  output logic                 baud_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);

  logic rx_s, fall_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  rx_state_e            state, state_n;
  logic                 en_n;
  logic [DATA_BITS-1:0] sh, sh_n, data_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 par, par_n;
  rx_status_t           stat, stat_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      baud_enable <= 1'b0;
      sh          <= '0;
      cnt         <= '0;
      par         <= 1'b0;
      rx_data     <= '0;
      stat        <= '0;
    end else begin
      state       <= state_n;
      baud_enable <= en_n;
      sh          <= sh_n;
      cnt         <= cnt_n;
      par         <= par_n;
      rx_data     <= data_n;
      stat        <= stat_n;
    end
  end

  always_comb begin
    state_n = state;
    en_n    = baud_enable;
    sh_n    = sh;
    cnt_n   = cnt;
    par_n   = par;
    data_n  = rx_data;
    stat_n  = '0;
    case (state)
      IDLE: if (fall_edge) begin
        en_n    = 1'b1;
        state_n = START;
      end
      START: if (clk_baud) begin
        if (!rx_s) begin
          state_n = DATA;
          cnt_n   = '0;
        end else begin
          // Glitch or noise: line was high again at mid start bit.
          en_n    = 1'b0;
          state_n = IDLE;
        end
      end
      DATA: if (clk_baud) begin
        sh_n  = {rx_s, sh[DATA_BITS-1:1]};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(DATA_BITS - 1)) state_n = PARITY_EN ? PARITY : STOP;
      end
      PARITY: if (clk_baud) begin
        par_n   = rx_s;
        state_n = STOP;
      end
      STOP: if (clk_baud) begin
        en_n    = 1'b0;
        state_n = IDLE;
        data_n  = sh;
        if (!rx_s)
          stat_n.frame_err = 1'b1;
        else if (PARITY_EN && (par != ((^sh) ^ PARITY_ODD)))
          stat_n.parity_err = 1'b1;
        else
          stat_n.valid = 1'b1;
      end
      default: begin
        en_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign rx_valid     = stat.valid;
  assign frame_error  = stat.frame_err;
  assign parity_error = stat.parity_err;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: a plain (no parity) and an even-parity instance,
// each fed by a 16 clk/bit baud model, checked against a frame-outcome queue.
module tb_uart_rx_frame;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic en0, en1, tick0, tick1;
  logic [7:0] d0, d1;
  logic v0, fe0, pe0, busy0, v1, fe1, pe1, busy1;
  int   bc0 = 0, bc1 = 0;

  always #5 clk = ~clk;

  // Baud generator model: first tick ~half a bit after enable, then every 16.
  always @(posedge clk) begin
    bc0 <= !en0 ? 0 : (bc0 == 15 ? 0 : bc0 + 1);
    bc1 <= !en1 ? 0 : (bc1 == 15 ? 0 : bc1 + 1);
  end
  assign tick0 = en0 && (bc0 == 7);
  assign tick1 = en1 && (bc1 == 7);

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .clk_baud(tick0), .baud_enable(en0),
    .rx_data(d0), .rx_valid(v0), .frame_error(fe0), .parity_error(pe0), .busy(busy0));

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .clk_baud(tick1), .baud_enable(en1),
    .rx_data(d1), .rx_valid(v1), .frame_error(fe1), .parity_error(pe1), .busy(busy1));

  typedef struct {
    logic [2:0] kind;   // {frame_error, parity_error, rx_valid}
    logic [7:0] data;
  } exp_t;

  exp_t q0[$], q1[$];
  int n_cmp = 0, n_err = 0;
  int nv0 = 0, nfe0 = 0, npe0 = 0, nv1 = 0, nfe1 = 0, npe1 = 0;

  // Outcome of a frame straight from the receive rules.
  function automatic logic [2:0] expect_kind(input logic [7:0] d, input bit has_par,
                                             input bit odd, input bit pbit, input bit stop);
    if (!stop) return 3'b100;
    if (has_par && (pbit != ((^d) ^ odd))) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [2:0] s, input logic [7:0] data);
    exp_t e;
    n_cmp++;
    if ($countones(s) != 1) begin
      n_err++;
      $display("FAIL dut%0d_onehot: strobes %b expected one-hot", d, s);
    end else if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_err++;
      $display("FAIL dut%0d_unexpected: strobes %b data %0h expected none", d, s, data);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (s !== e.kind || data !== e.data) begin
        n_err++;
        $display("FAIL dut%0d_frame: strobes %b data %0h expected %b data %0h",
                 d, s, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if ({fe0, pe0, v0} != 3'b000) cmp_dut(0, {fe0, pe0, v0}, d0);
    if ({fe1, pe1, v1} != 3'b000) cmp_dut(1, {fe1, pe1, v1}, d1);
    nv0 += int'(v0); nfe0 += int'(fe0); npe0 += int'(pe0);
    nv1 += int'(v1); nfe1 += int'(fe1); npe1 += int'(pe1);
  end

  task automatic drive_bit(input int d, input logic b);
    if (d == 0) rx0 = b; else rx1 = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input bit has_par,
                            input bit pbit, input bit stop);
    exp_t e;
    e.kind = expect_kind(data, has_par, 1'b0, pbit, stop);
    e.data = data;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    drive_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
    if (has_par) drive_bit(d, pbit);
    drive_bit(d, stop);
  endtask

  task automatic drain(input int d, input string name);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 64) begin
      @(negedge clk); n++;
    end
    chk(name, (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    int sv, sfe, spe, bh;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_en", en0, 0);
    chk("rst_data", d0, 0);
    chk("rst_strobes", {fe0, pe0, v0, fe1, pe1, v1}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Test 1: plain 0x55
    sv = nv0;
    send_frame(0, 8'h55, 0, 0, 1);
    drain(0, "t1_drain");
    chk("t1_data", d0, 8'h55);
    chk("t1_valid_cycles", nv0 - sv, 1);
    chk("t1_en_low", en0, 0);
    chk("t1_busy_low", busy0, 0);

    // Test 2: bad stop bit, line held low (break)
    sv = nv0; sfe = nfe0; bh = 0;
    send_frame(0, 8'hA3, 0, 0, 0);
    repeat (40) begin @(negedge clk); bh += int'(busy0); end
    drain(0, "t2_drain");
    chk("t2_fe_cycles", nfe0 - sfe, 1);
    chk("t2_valid", nv0 - sv, 0);
    chk("t2_data", d0, 8'hA3);
    chk("t2_no_rearm", bh, 0);
    rx0 = 1'b1;
    repeat (32) @(negedge clk);

    // Test 3: 3-cycle glitch is a false start
    sv = nv0; sfe = nfe0; seen = 0;
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) begin @(negedge clk); if (en0) seen = 1; end
    chk("t3_en_pulsed", seen, 1);
    chk("t3_en_low", en0, 0);
    chk("t3_busy_low", busy0, 0);
    chk("t3_no_strobe", (nv0 - sv) + (nfe0 - sfe), 0);

    // Test 4: even parity, data 0x07 (odd number of ones)
    sv = nv1; spe = npe1;
    send_frame(1, 8'h07, 1, 0, 1);
    drain(1, "t4a_drain");
    chk("t4a_pe_cycles", npe1 - spe, 1);
    chk("t4a_valid", nv1 - sv, 0);
    repeat (20) @(negedge clk);
    sv = nv1; spe = npe1;
    send_frame(1, 8'h07, 1, 1, 1);
    drain(1, "t4b_drain");
    chk("t4b_valid_cycles", nv1 - sv, 1);
    chk("t4b_pe", npe1 - spe, 0);
    chk("t4b_data", d1, 8'h07);

    // Test 5: reset after 4 data bits of 0xFF
    sv = nv0; sfe = nfe0;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy", busy0, 0);
    chk("t5_en", en0, 0);
    repeat (120) @(negedge clk);
    chk("t5_no_strobe", (nv0 - sv) + (nfe0 - sfe), 0);
    send_frame(0, 8'h3C, 0, 0, 1);
    drain(0, "t5_drain");
    chk("t5_data", d0, 8'h3C);
    chk("t5_valid_cycles", nv0 - sv, 1);

    // Test 6: back-to-back frames, no idle gap
    sv = nv0;
    send_frame(0, 8'h01, 0, 0, 1);
    chk("t6_first_data", d0, 8'h01);
    send_frame(0, 8'hFE, 0, 0, 1);
    drain(0, "t6_drain");
    chk("t6_valid_cycles", nv0 - sv, 2);
    chk("t6_data", d0, 8'hFE);

    repeat (20) @(negedge clk);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Receive-side framing FSM of the UART, directly downstream of the receive baud generator.
- Enables the generator while a frame is in progress. Consumes its mid-bit clk_baud tick to sample the synchronised serial line.
- Assembles LSB-first data with an optional parity bit and checks the stop bit.
- Presents each received byte with a one-cycle valid strobe and error flags to the host logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- clk_baud  input  1  single-cycle tick from the baud generator. First tick comes about half a bit after enable, then one tick per bit period.
- baud_enable  output  1  runs the baud generator; high from start-edge detection to end of frame.
- rx_data  output  DATA_BITS  last received data word; holds until the next frame completes.
- rx_valid  output  1  one-cycle strobe: rx_data updated, no errors.
- frame_error  output  1  one-cycle strobe: stop bit sampled low.
- parity_error  output  1  one-cycle strobe: parity mismatch, stop bit good.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, baud_enable=0, rx_data=0, rx_valid=0, frame_error=0, parity_error=0, busy=0, bit counter=0, shift register=0.
  - Synchroniser flops reset to 1 (idle line).
- rx passes through a 2-FF synchroniser. A third flop holds the previous synchronised value for edge detection.
- IDLE:
  - On a synchronised falling edge (prev=1, cur=0): baud_enable<=1, go to START.
  - A line that stays low (break) never re-arms; a 1 must be seen first.
- START: on clk_baud, sample the line.
  - 0 -> DATA, bit counter=0.
  - 1 -> false start: baud_enable<=0, go to IDLE, no strobes.
- DATA: on each clk_baud, shift the sample into the MSB end of the shift register (shift right), so data arrives LSB-first.
  - After DATA_BITS ticks: go to PARITY if PARITY_EN, else STOP.
  - Counter width is clog2(DATA_BITS+1); it never wraps.
- PARITY: on clk_baud, latch the sample as the received parity bit, go to STOP.
  - Expected parity = XOR of data bits XOR PARITY_ODD.
- STOP: on clk_baud, baud_enable<=0, state<=IDLE, rx_data<=shift register (always loaded). In the following cycle exactly one of:
  - frame_error=1 if the stop sample is 0.
  - otherwise parity_error=1 if PARITY_EN and a mismatch exists.
  - otherwise rx_valid=1.
- Latency: strobe appears one clk after the stop-bit tick. Strobes are never asserted together and last exactly one cycle.
- clk_baud arriving in IDLE is ignored.
- Between ticks, all state is held.
- Back-to-back frames:
  - Stop sample is mid-bit, so the FSM is back in IDLE before the next start edge.
  - The edge is detected from the stop-bit high, with no idle gap required.
- Reset mid-frame: frame abandoned, no strobe; next frame received normally.
- Reset coincident with clk_baud: reset wins.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP; 3 bits).
  - default DATA_BITS.
  - parity-mode constants, shared with the transmitter.
- One sub-module: uart_rx_sync, a 2-FF synchroniser plus previous-value flop. Outputs rx_s and fall_edge; reset-to-1.

Test Plan:
- Bench setup: clk_baud comes from the team's baud generator at 16 clk/bit, wired to baud_enable.
- Test 1: frame 0x55, stop=1, PARITY_EN=0 -> rx_data=0x55, rx_valid high exactly 1 cycle, errors 0, baud_enable low after stop.
- Test 2: frame 0xA3 with stop bit 0, then line held low 40 cycles -> frame_error 1 cycle, rx_data=0xA3, rx_valid 0. No re-arm until rx returns high.
- Test 3: rx low pulse of 3 cycles, then high -> baud_enable pulses then drops in START. busy returns 0, no strobes.
- Test 4: PARITY_EN=1, PARITY_ODD=0, data 0x07 sent with parity bit 0 -> parity_error 1 cycle, rx_valid 0. Same data with parity 1 -> rx_valid, rx_data=0x07.
- Test 5: reset asserted for 1 cycle after 4 data bits of 0xFF -> next cycle busy=0, baud_enable=0, no strobe. Following frame 0x3C -> rx_valid, rx_data=0x3C.
- Test 6: frames 0x01 then 0xFE with no idle gap (start bit immediately after stop) -> two rx_valid strobes with rx_data 0x01 then 0xFE.
